pll_ctl: RTL and testbench

PLL_CTL -- requirements
Module: pll_ctl

---
 rtl/pll_ctl.sv | 127 ++++++++++++
 tb/tb_pll_ctl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_ctl.sv
// PLL bring-up sequencer: standby, lock wait, settle, run and failure handling.
// Emits fixed divider settings and a registered clock-good / system reset pair.
module pll_ctl #(
  parameter int STBY_CYCLES   = 16,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       relock,
  input  logic       pll_lock,
  output logic       pll_stby,
  output logic       pll_pbstby,
  output logic       pll_pcstby,
  output logic       pll_m0,
  output logic [3:0] pll_n,
  output logic [3:0] pll_pa,
  output logic [3:0] pll_pb,
  output logic [3:0] pll_pc,
  output logic       clk_ok,
  output logic       sys_reset_l,
  output logic       lock_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  localparam logic [11:0] STBY_LAST   = 12'(STBY_CYCLES - 1);
  localparam logic [11:0] TMO_LAST    = 12'(LOCK_TIMEOUT - 1);
  localparam logic [11:0] SETTLE_LAST = 12'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic        meta_q, lock_s_q;
  logic        err_q, err_d;
  logic        stby_q, ok_q, srst_q;

  // Dividers must be stable before lock, so they are hard-wired.
  assign pll_pbstby = 1'b1;
  assign pll_pcstby = 1'b1;
  assign pll_m0     = 1'b1;
  assign pll_n      = 4'd7;
  assign pll_pa     = 4'd1;
  assign pll_pb     = 4'd1;
  assign pll_pc     = 4'd1;

  assign pll_stby    = stby_q;
  assign clk_ok      = ok_q;
  assign sys_reset_l = srst_q;
  assign lock_err    = err_q;
  assign state       = state_q;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_lock;
      lock_s_q <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_HOLD: begin
        if (cnt_q == STBY_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lock_s_q) begin
          state_d = S_SETTLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAIL;
          err_d   = 1'b1;
        end
      end
      S_SETTLE: begin
        if (!lock_s_q) state_d = S_HOLD;
        else if (cnt_q == SETTLE_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (relock) begin
          state_d = S_HOLD;
          err_d   = 1'b0;
        end else if (!lock_s_q) begin
          state_d = S_HOLD;
          err_d   = 1'b1;
        end
      end
      S_FAIL: begin
        if (relock) begin
          state_d = S_HOLD;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_HOLD;
    endcase
    cnt_d = (state_d != state_q) ? 12'd0 : cnt_q + 12'd1;
  end

  // Output flops follow the next state so they switch with the state register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_HOLD;
      cnt_q   <= 12'd0;
      err_q   <= 1'b0;
      stby_q  <= 1'b1;
      ok_q    <= 1'b0;
      srst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stby_q  <= (state_d == S_HOLD) || (state_d == S_FAIL);
      ok_q    <= (state_d == S_RUN);
      srst_q  <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_ctl.sv
// Testbench for pll_ctl: random lock/relock traffic against a cycle model,
// plus directed boot, loss, timeout and asynchronous reset scenarios.
module tb_pll_ctl;
  localparam int STBY    = 16;
  localparam int TMO     = 1024;
  localparam int SETL    = 64;
  localparam int PLL_DLY = 8;

  logic       clk = 1'b0;
  logic       reset_l, relock, pll_lock;
  logic       pll_stby, pll_pbstby, pll_pcstby, pll_m0;
  logic [3:0] pll_n, pll_pa, pll_pb, pll_pc;
  logic       clk_ok, sys_reset_l, lock_err;
  logic [2:0] state;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: state, cycles spent in it, sticky error, lock history.
  logic [2:0] m_st;
  int         m_tis;
  bit         m_err;
  bit   [1:0] m_sy;
  int         m_low;

  pll_ctl #(
    .STBY_CYCLES  (STBY),
    .LOCK_TIMEOUT (TMO),
    .SETTLE_CYCLES(SETL)
  ) dut (
    .clk        (clk),
    .reset_l    (reset_l),
    .relock     (relock),
    .pll_lock   (pll_lock),
    .pll_stby   (pll_stby),
    .pll_pbstby (pll_pbstby),
    .pll_pcstby (pll_pcstby),
    .pll_m0     (pll_m0),
    .pll_n      (pll_n),
    .pll_pa     (pll_pa),
    .pll_pb     (pll_pb),
    .pll_pc     (pll_pc),
    .clk_ok     (clk_ok),
    .sys_reset_l(sys_reset_l),
    .lock_err   (lock_err),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {state, pll_stby, clk_ok, sys_reset_l, lock_err};
  endfunction

  function automatic logic [6:0] m_outs();
    bit run;
    run = (m_st == 3'd3);
    return {m_st, (m_st == 3'd0) || (m_st == 3'd4), run, run, m_err};
  endfunction

  function automatic logic [18:0] divs();
    return {pll_pbstby, pll_pcstby, pll_m0, pll_n, pll_pa, pll_pb, pll_pc};
  endfunction

  function automatic void m_reset();
    m_st  = 3'd0;
    m_tis = 0;
    m_err = 1'b0;
    m_sy  = 2'b00;
    m_low = 0;
  endfunction

  function automatic void m_step();
    bit         ls;
    logic [2:0] nx;
    ls = m_sy[1];
    nx = m_st;
    case (m_st)
      3'd0: if (m_tis + 1 >= STBY) nx = 3'd1;
      3'd1: begin
        if (ls) nx = 3'd2;
        else if (m_tis + 1 >= TMO) begin nx = 3'd4; m_err = 1'b1; end
      end
      3'd2: begin
        if (!ls) nx = 3'd0;
        else if (m_tis + 1 >= SETL) nx = 3'd3;
      end
      3'd3: begin
        if (relock) begin nx = 3'd0; m_err = 1'b0; end
        else if (!ls) begin nx = 3'd0; m_err = 1'b1; end
      end
      3'd4: if (relock) begin nx = 3'd0; m_err = 1'b0; end
      default: nx = 3'd0;
    endcase
    m_tis = (nx != m_st) ? 0 : m_tis + 1;
    m_st  = nx;
    m_sy  = {m_sy[0], pll_lock};
    if (m_st == 3'd0 || m_st == 3'd4) m_low = 0;
    else m_low++;
  endfunction

  // mode 0: PLL model locks PLL_DLY cycles after standby drops; mode 1: tied 0.
  task automatic run_cycles(input int n, input int mode, input int drop_at,
                            input int relock_at, input int rl_rate,
                            input int gl_rate);
    for (int i = 0; i < n; i++) begin
      bit gl;
      relock = (i == relock_at) ||
               (rl_rate > 0 && $urandom_range(rl_rate - 1) == 0);
      gl = (i == drop_at) ||
           (gl_rate > 0 && $urandom_range(gl_rate - 1) == 0);
      pll_lock = (mode == 0) && (m_low >= PLL_DLY) && !gl;
      @(posedge clk);
      m_step();
      #1;
      chk("outputs", 32'(outs()), 32'(m_outs()));
      chk("dividers", 32'(divs()), 32'({3'b111, 4'd7, 4'd1, 4'd1, 4'd1}));
    end
    relock = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int k;
    k = 0;
    while (m_st != s && k < 5000) begin
      run_cycles(1, 0, -1, -1, 0, 0);
      k++;
    end
    chk("reach_state", 32'(state), 32'(s));
  endtask

  task automatic wait_settle(input int tis);
    int k;
    k = 0;
    while (!(m_st == 3'd2 && m_tis == tis) && k < 5000) begin
      run_cycles(1, 0, -1, -1, 0, 0);
      k++;
    end
    chk("reach_settle", 32'(state), 32'd2);
  endtask

  task automatic async_reset(input string tag);
    #2 reset_l = 1'b0;
    #1;
    m_reset();
    chk(tag, 32'(outs()), 32'(7'b000_1000));
    #2 reset_l = 1'b1;
  endtask

  initial begin
    reset_l  = 1'b1;
    relock   = 1'b0;
    pll_lock = 1'b0;
    #1 reset_l = 1'b0;
    #1;
    m_reset();
    chk("por", 32'(outs()), 32'(7'b000_1000));
    repeat (3) @(posedge clk);
    #2 reset_l = 1'b1;

    run_cycles(120, 0, -1, -1, 0, 0);
    chk("boot_state", 32'(state), 32'd3);
    chk("boot_clk_ok", 32'(clk_ok), 32'd1);
    chk("boot_srst", 32'(sys_reset_l), 32'd1);
    chk("boot_err", 32'(lock_err), 32'd0);

    run_cycles(3, 0, 0, -1, 0, 0);
    chk("loss_state", 32'(state), 32'd0);
    chk("loss_err", 32'(lock_err), 32'd1);
    chk("loss_clk_ok", 32'(clk_ok), 32'd0);
    chk("loss_srst", 32'(sys_reset_l), 32'd0);
    wait_state(3'd3);

    run_cycles(1, 0, -1, 0, 0, 0);
    chk("relock_state", 32'(state), 32'd0);
    chk("relock_clr", 32'(lock_err), 32'd0);

    wait_settle(28);
    run_cycles(3, 0, 0, -1, 0, 0);
    chk("settle_drop", 32'(state), 32'd0);
    chk("settle_err", 32'(lock_err), 32'd0);
    run_cycles(40, 0, -1, -1, 3, 0);
    chk("relock_ignored", 32'(state), 32'd2);
    wait_state(3'd3);

    run_cycles(3, 0, 0, 2, 0, 0);
    chk("loss_relock_state", 32'(state), 32'd0);
    chk("loss_relock_err", 32'(lock_err), 32'd0);

    run_cycles(STBY + TMO - 1, 1, -1, -1, 0, 0);
    chk("pre_timeout", 32'(state), 32'd1);
    run_cycles(1, 1, -1, -1, 0, 0);
    chk("fail_state", 32'(state), 32'd4);
    chk("fail_err", 32'(lock_err), 32'd1);
    chk("fail_stby", 32'(pll_stby), 32'd1);
    run_cycles(5, 1, -1, -1, 0, 0);
    chk("fail_stays", 32'(state), 32'd4);
    run_cycles(1, 1, -1, 0, 0, 0);
    chk("fail_relock", 32'(state), 32'd0);
    chk("fail_relock_err", 32'(lock_err), 32'd0);

    wait_settle(10);
    async_reset("rst_settle");
    wait_state(3'd3);
    async_reset("rst_run");

    for (int s = 0; s < 12; s++)
      run_cycles(1500, ($urandom_range(3) == 0) ? 1 : 0, -1, -1, 400, 1200);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
